// File: rtl/program_memory_loader.sv
// program_memory_loader
//   Packs an 8-bit stream little-endian into 32-bit words, writes them to
//   consecutive words of a single-port program RAM starting at start_addr,
//   then (VERIFY_EN=1) reads the written range back and compares an additive
//   checksum before pulsing done.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   start, start_addr      load request (sampled only in IDLE) and first word address
//   s_data/s_valid/s_last  byte stream in; s_ready is high only while packing
//   address .. clken       RAM master side (1-cycle read latency on readdata)
//   busy, done, error      status; error is sticky until the next accepted start
//   word_count, checksum   words written and their sum mod 2^32 (unused lanes zeroed)
module program_memory_loader #(
  parameter int ADDR_W    = 15,
  parameter int DEPTH     = 32768,
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              clken,
  input  logic [31:0]       readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count,
  output logic [31:0]       checksum
);

  localparam int NUM_LANES = 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PACK, S_WRITE, S_VRD, S_VCMP, S_DONE
  } state_t;

  state_t                              state_q, state_d;
  logic [ADDR_W-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [1:0]                          lane_q, lane_d;
  logic [NUM_LANES-1:0][7:0]           data_q, data_d;
  logic [NUM_LANES-1:0]                be_q, be_d;
  logic [NUM_LANES-1:0]                last_be_q, last_be_d;
  logic                                final_q, final_d;
  logic [15:0]                         word_count_q, word_count_d;
  logic [15:0]                         rd_cnt_q, rd_cnt_d;
  logic [31:0]                         checksum_q, checksum_d;
  logic [31:0]                         rd_sum_q, rd_sum_d;
  logic                                error_q, error_d;

  // Expand a byte-enable into a 32-bit lane mask.
  function automatic logic [31:0] lane_mask(input logic [NUM_LANES-1:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < NUM_LANES; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lane_q       <= '0;
      data_q       <= '0;
      be_q         <= '0;
      last_be_q    <= '0;
      final_q      <= 1'b0;
      word_count_q <= '0;
      rd_cnt_q     <= '0;
      checksum_q   <= '0;
      rd_sum_q     <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      lane_q       <= lane_d;
      data_q       <= data_d;
      be_q         <= be_d;
      last_be_q    <= last_be_d;
      final_q      <= final_d;
      word_count_q <= word_count_d;
      rd_cnt_q     <= rd_cnt_d;
      checksum_q   <= checksum_d;
      rd_sum_q     <= rd_sum_d;
      error_q      <= error_d;
    end
  end

  // Next state and datapath
  logic [15:0] rd_cnt_n;
  logic [31:0] rd_sum_n;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    lane_d       = lane_q;
    data_d       = data_q;
    be_d         = be_q;
    last_be_d    = last_be_q;
    final_d      = final_q;
    word_count_d = word_count_q;
    rd_cnt_d     = rd_cnt_q;
    checksum_d   = checksum_q;
    rd_sum_d     = rd_sum_q;
    error_d      = error_q;
    rd_cnt_n     = rd_cnt_q + 16'd1;
    rd_sum_n     = rd_sum_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_ptr_d     = start_addr;
          rd_ptr_d     = start_addr;
          lane_d       = '0;
          data_d       = '0;
          be_d         = '0;
          final_d      = 1'b0;
          word_count_d = '0;
          rd_cnt_d     = '0;
          checksum_d   = '0;
          rd_sum_d     = '0;
          error_d      = 1'b0;
          state_d      = S_PACK;
        end
      end
      S_PACK: begin
        if (s_valid) begin
          // Lane 0 opens a new word: drop the previous word's bytes/enables.
          if (lane_q == 2'd0) begin
            data_d = '0;
            be_d   = '0;
          end
          data_d[lane_q] = s_data;
          be_d[lane_q]   = 1'b1;
          lane_d         = lane_q + 2'd1;
          if (lane_q == 2'd3 || s_last) begin
            final_d = s_last;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        checksum_d   = checksum_q + (data_q & lane_mask(be_q));
        word_count_d = (word_count_q == 16'hFFFF) ? word_count_q : word_count_q + 16'd1;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        lane_d       = '0;
        last_be_d    = be_q;
        if (final_q) begin
          state_d = VERIFY_EN ? S_VRD : S_DONE;
        end else if (wr_ptr_q == LAST_ADDR) begin
          error_d = 1'b1;   // image ran past the end of RAM; never wrap
          state_d = S_DONE;
        end else begin
          state_d = S_PACK;
        end
      end
      S_VRD: state_d = S_VCMP;
      S_VCMP: begin
        // The last word may be partial; ignore lanes that were never written.
        rd_sum_n = rd_sum_q + ((rd_cnt_n == word_count_q) ? (readdata & lane_mask(last_be_q))
                                                          : readdata);
        rd_sum_d = rd_sum_n;
        rd_cnt_d = rd_cnt_n;
        if (rd_cnt_n == word_count_q) begin
          if (rd_sum_n != checksum_q) error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          state_d  = S_VRD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: decoded from state, data/address straight from registers
  always_comb begin
    s_ready    = (state_q == S_PACK);
    chipselect = (state_q == S_WRITE) || (state_q == S_VRD);
    write      = (state_q == S_WRITE);
    address    = (state_q == S_VRD) ? rd_ptr_q : wr_ptr_q;
    byteenable = (state_q == S_WRITE) ? be_q :
                 (state_q == S_VRD)   ? 4'hF : 4'h0;
    writedata  = data_q;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    error      = error_q;
    word_count = word_count_q;
    checksum   = checksum_q;
  end

  assign clken = 1'b1;

endmodule

// File: tb/tb_program_memory_loader.sv
// Bench for program_memory_loader: two instances (verify on / verify off)
// share one stimulus; each has its own RAM model. Expected RAM writes are
// queued by a reference packer and popped as write strobes appear.
module tb_program_memory_loader;

  localparam int DEPTH = 32768;

  typedef struct {
    logic [14:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [14:0] start_addr = '0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;

  logic        u0_s_ready, u0_cs, u0_wr, u0_clken, u0_busy, u0_done, u0_error;
  logic [14:0] u0_addr;
  logic [3:0]  u0_be;
  logic [31:0] u0_wdata, u0_rdata, u0_checksum;
  logic [15:0] u0_wc;
  logic        u1_s_ready, u1_cs, u1_wr, u1_clken, u1_busy, u1_done, u1_error;
  logic [14:0] u1_addr;
  logic [3:0]  u1_be;
  logic [31:0] u1_wdata, u1_rdata, u1_checksum;
  logic [15:0] u1_wc;

  program_memory_loader #(.ADDR_W(15), .DEPTH(DEPTH), .VERIFY_EN(1'b1)) u0 (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(u0_s_ready),
    .address(u0_addr), .byteenable(u0_be), .chipselect(u0_cs), .write(u0_wr),
    .writedata(u0_wdata), .clken(u0_clken), .readdata(u0_rdata),
    .busy(u0_busy), .done(u0_done), .error(u0_error),
    .word_count(u0_wc), .checksum(u0_checksum));

  program_memory_loader #(.ADDR_W(15), .DEPTH(DEPTH), .VERIFY_EN(1'b0)) u1 (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(u1_s_ready),
    .address(u1_addr), .byteenable(u1_be), .chipselect(u1_cs), .write(u1_wr),
    .writedata(u1_wdata), .clken(u1_clken), .readdata(u1_rdata),
    .busy(u1_busy), .done(u1_done), .error(u1_error),
    .word_count(u1_wc), .checksum(u1_checksum));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr0 = 0, last_wr1 = 0;
  int addr0_hits = 0;
  bit watch0 = 0;
  bit corrupt = 0;
  logic [14:0] corrupt_addr = '0;
  wr_t q0[$], q1[$];
  wr_t e0, e1;

  logic [31:0] mem0 [DEPTH];
  logic [31:0] mem1 [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bemask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // RAM models: byte-enabled write, registered 1-cycle read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (u0_cs) begin
      if (u0_wr) begin
        for (int i = 0; i < 4; i++)
          if (u0_be[i]) mem0[u0_addr][8*i +: 8] <= u0_wdata[8*i +: 8];
      end else begin
        u0_rdata <= mem0[u0_addr] ^ ((corrupt && u0_addr == corrupt_addr) ? 32'h0000_0100 : 32'h0);
      end
    end
    if (u1_cs) begin
      if (u1_wr) begin
        for (int j = 0; j < 4; j++)
          if (u1_be[j]) mem1[u1_addr][8*j +: 8] <= u1_wdata[8*j +: 8];
      end else begin
        u1_rdata <= mem1[u1_addr];
      end
    end
  end

  // Write-strobe monitors
  always @(negedge clk) begin
    if (watch0 && ((u0_cs && u0_addr == 15'd0) || (u1_cs && u1_addr == 15'd0))) addr0_hits++;
    if (!reset && u0_cs && u0_wr) begin
      last_wr0 = cyc;
      if (q0.size() == 0) chk("u0_wr_unexpected", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("u0_wr_addr", u0_addr, e0.addr);
        chk("u0_wr_be", u0_be, e0.be);
        chk("u0_wr_data", u0_wdata & bemask(u0_be), e0.data);
      end
    end
    if (!reset && u1_cs && u1_wr) begin
      last_wr1 = cyc;
      if (q1.size() == 0) chk("u1_wr_unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("u1_wr_addr", u1_addr, e1.addr);
        chk("u1_wr_be", u1_be, e1.be);
        chk("u1_wr_data", u1_wdata & bemask(u1_be), e1.data);
      end
    end
  end

  // Reference packer: queues expected writes, returns accepted-byte count and totals
  task automatic model(input logic [14:0] sa, input logic [7:0] b[$], input bit has_last,
                       output int n_acc, output int wc, output logic [31:0] cs, output bit ovf);
    logic [14:0] a;
    logic [31:0] w;
    logic [3:0]  be;
    int k;
    bit fin;
    wr_t e;
    a = sa; w = '0; be = '0; k = 0;
    n_acc = 0; wc = 0; cs = '0; ovf = 0;
    for (int i = 0; i < b.size(); i++) begin
      fin = has_last && (i == b.size() - 1);
      w[8*k +: 8] = b[i];
      be[k] = 1'b1;
      k++;
      n_acc++;
      if (k == 4 || fin) begin
        e.addr = a; e.be = be; e.data = w;
        q0.push_back(e);
        q1.push_back(e);
        cs += w;
        wc++;
        if (fin) break;
        if (a == 15'h7FFF) begin ovf = 1; break; end
        a++; k = 0; w = '0; be = '0;
      end
    end
  endtask

  task automatic do_start(input logic [14:0] sa);
    @(negedge clk);
    start = 1'b1;
    start_addr = sa;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b[$], input int n, input bit has_last, input bit gaps);
    int i, t;
    bit hs;
    i = 0; t = 0;
    while (i < n && t < 2000) begin
      @(negedge clk);
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data  = b[i];
      s_last  = has_last && (i == b.size() - 1);
      hs = s_valid && u0_s_ready;
      @(posedge clk);
      if (hs) i++;
      t++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("send_bytes_accepted", i, n);
  endtask

  task automatic wait_done(input int which, input string tag, output int dcyc);
    int t;
    bit seen;
    t = 0;
    seen = (which == 0) ? u0_done : u1_done;
    while (!seen && t < 1000) begin
      @(negedge clk);
      seen = (which == 0) ? u0_done : u1_done;
      t++;
    end
    chk({tag, "_done_seen"}, seen, 1);
    dcyc = cyc;
  endtask

  task automatic run_test(input string tag, input logic [14:0] sa, input logic [7:0] b[$],
                          input bit has_last, input bit gaps, input bit pulse, input bit bad_rd);
    int n_acc, wc, d0, d1;
    logic [31:0] cs;
    bit ovf;
    model(sa, b, has_last, n_acc, wc, cs, ovf);
    do_start(sa);
    fork
      send(b, n_acc, has_last, gaps);
      begin
        if (pulse) begin
          repeat (6) @(negedge clk);
          start = 1'b1;
          start_addr = 15'h0123;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    wait_done(1, {tag, "_u1"}, d1);
    chk({tag, "_u1_error"}, u1_error, ovf);
    chk({tag, "_u1_word_count"}, u1_wc, wc);
    chk({tag, "_u1_checksum"}, u1_checksum, cs);
    chk({tag, "_u1_done_latency"}, d1 - last_wr1, 1);
    chk({tag, "_u1_writes_left"}, q1.size(), 0);
    wait_done(0, {tag, "_u0"}, d0);
    chk({tag, "_u0_error"}, u0_error, ovf | bad_rd);
    chk({tag, "_u0_word_count"}, u0_wc, wc);
    chk({tag, "_u0_checksum"}, u0_checksum, cs);
    chk({tag, "_u0_done_latency"}, d0 - last_wr0, (has_last && !ovf) ? 2 * wc + 1 : 1);
    chk({tag, "_u0_writes_left"}, q0.size(), 0);
    @(negedge clk);
    chk({tag, "_done_pulse_width"}, {u0_done, u1_done}, 2'b00);
    chk({tag, "_idle_after"}, {u0_busy, u1_busy}, 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[$];
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {u0_busy, u1_busy}, 2'b00);
    chk("rst_s_ready", u0_s_ready, 0);
    chk("rst_cs_wr", {u0_cs, u0_wr}, 2'b00);
    chk("rst_clken", {u0_clken, u1_clken}, 2'b11);
    chk("rst_done_error", {u0_done, u0_error}, 2'b00);
    chk("rst_addr_be", {u0_addr, u0_be}, 0);
    chk("rst_wdata", u0_wdata, 0);
    chk("rst_wc_cs", {u0_wc, u0_checksum}, 0);
    reset = 1'b0;

    // T1: two full words from address 0
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_test("t1", 15'h0000, bq, 1, 0, 0, 0);
    chk("t1_checksum_const", u0_checksum, 32'hCCAA8866);
    chk("t1_ram0", mem0[0], 32'h44332211);
    chk("t1_ram1", mem0[1], 32'h88776655);

    // T2: partial final word
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_test("t2", 15'h0010, bq, 1, 0, 0, 0);
    chk("t2_checksum_const", u0_checksum, 32'h04030806);
    chk("t2_ram_last_lo", mem0[15'h0011][15:0], 16'h0605);

    // T3: overflow at the last RAM word
    watch0 = 1;
    bq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    run_test("t3", 15'h7FFF, bq, 0, 0, 0, 0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    repeat (4) begin
      @(negedge clk);
      chk("t3_no_ready_after", {u0_s_ready, u1_s_ready, u0_cs, u1_cs}, 4'b0000);
    end
    s_valid = 1'b0;
    watch0 = 0;
    chk("t3_no_addr0_access", addr0_hits, 0);

    // T5: reset mid-pack, then a clean load from lane 0
    do_start(15'h0200);
    bq = '{8'hEE, 8'hDD};
    send(bq, 2, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", {u0_busy, u1_busy}, 2'b00);
    chk("t5_rst_ready_cs", {u0_s_ready, u0_cs, u1_s_ready, u1_cs}, 4'b0000);
    chk("t5_rst_error", u0_error, 0);
    reset = 1'b0;
    bq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_test("t5", 15'h0200, bq, 1, 0, 0, 0);

    // T4: corrupted readback of the second word
    corrupt = 1;
    corrupt_addr = 15'h0101;
    bq = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0};
    run_test("t4", 15'h0100, bq, 1, 0, 0, 1);
    corrupt = 0;

    // T6: gapped stream, start pulsed while busy; error from T4 cleared
    bq = {};
    for (int i = 0; i < 19; i++) bq.push_back(8'($urandom));
    run_test("t6", 15'h0040, bq, 1, 1, 1, 0);
    chk("t6_ram_first", mem1[15'h0040], {bq[3], bq[2], bq[1], bq[0]});
    chk("t6_ram_last", mem1[15'h0044] & 32'h00FF_FFFF, {8'h00, bq[18], bq[17], bq[16]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
